// File: rtl/multdiv_iterative_if.sv
// Request/response bundle between the execute stage and the iterative multiply/divide unit.
// The master issues start pulses and operands; the slave returns the result with a ready pulse.
interface multdiv_iterative_if #(
    parameter int WIDTH = 32
);
    logic             ctrl_MULT;
    logic             ctrl_DIV;
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;

    modport master (
        output ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
        input  data_result, data_exception, data_resultRDY
    );

    modport slave (
        input  ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
        output data_result, data_exception, data_resultRDY
    );
endinterface

// File: rtl/multdiv_iterative.sv
// Signed 32-bit multiply (radix-2 Booth) and divide (non-restoring on magnitudes),
// one iteration per cycle with a fixed 33-cycle start-to-ready latency.
module multdiv_iterative #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input logic                  clock,
    input logic                  reset,
    multdiv_iterative_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_e;

    // Shared accumulator: MULT uses [2W:0] as the Booth product register,
    // DIV uses {remainder[W+1:0], quotient[W-1:0]}.
    localparam int AW = 2*WIDTH + 2;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]      acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic               neg_q, neg_d;
    logic               dbz_q, dbz_d;
    logic               ovf_q, ovf_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               exc_q, exc_d;

    logic               last;
    logic [WIDTH:0]     m_hi, m_a, m_sum;
    logic [WIDTH+1:0]   d_rem, d_shift, d_div, d_new;
    logic [AW-1:0]      acc_step;
    logic [WIDTH-1:0]   quot, abs_a, abs_b;

    assign last  = (cnt_q == CNT_W'(WIDTH-1));
    assign abs_a = bus.data_operandA[WIDTH-1] ? -bus.data_operandA : bus.data_operandA;
    assign abs_b = bus.data_operandB[WIDTH-1] ? -bus.data_operandB : bus.data_operandB;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // A start pulse preempts whatever is running; MULT has priority over DIV.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
        state_d = state_q;
        if (bus.ctrl_MULT)     state_d = MULT;
        else if (bus.ctrl_DIV) state_d = DIV;
        else begin
            case (state_q)
                MULT, DIV: if (last) state_d = DONE;
                DONE:      state_d = IDLE;
                default:   state_d = state_q;
            endcase
        end
    end

    always_comb begin
        bus.data_resultRDY = (state_q == DONE);
        bus.data_result    = result_q;
        bus.data_exception = exc_q;
    end

    // One iteration of each algorithm; the state selects which one is committed.
    always_comb begin
        m_hi  = {acc_q[2*WIDTH], acc_q[2*WIDTH:WIDTH+1]};
        m_a   = {opnd_q[WIDTH-1], opnd_q};
        case (acc_q[1:0])
            2'b01:   m_sum = m_hi + m_a;
            2'b10:   m_sum = m_hi - m_a;
            default: m_sum = m_hi;
        endcase

        d_rem   = acc_q[AW-1:WIDTH];
        d_shift = {d_rem[WIDTH:0], acc_q[WIDTH-1]};
        d_div   = {2'b00, opnd_q};
        d_new   = d_rem[WIDTH+1] ? d_shift + d_div : d_shift - d_div;

        if (state_q == MULT) acc_step = {m_sum[WIDTH], m_sum, acc_q[WIDTH:1]};
        else                 acc_step = {d_new, acc_q[WIDTH-2:0], ~d_new[WIDTH+1]};

        // Quotient bits are exact; the remainder correction step is skipped since it is discarded.
        quot = acc_step[WIDTH-1:0];
    end

    always_comb begin
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        dbz_d    = dbz_q;
        ovf_d    = ovf_q;
        result_d = result_q;
        exc_d    = exc_q;
        if (bus.ctrl_MULT) begin
            acc_d  = {{(WIDTH+1){1'b0}}, bus.data_operandB, 1'b0};
            opnd_d = bus.data_operandA;
            cnt_d  = '0;
        end else if (bus.ctrl_DIV) begin
            acc_d  = {{(WIDTH+2){1'b0}}, abs_a};
            opnd_d = abs_b;
            neg_d  = bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
            dbz_d  = (bus.data_operandB == '0);
            ovf_d  = (bus.data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) && (bus.data_operandB == '1);
            cnt_d  = '0;
        end else if (state_q == MULT || state_q == DIV) begin
            acc_d = acc_step;
            cnt_d = cnt_q + CNT_W'(1);
            if (last && state_q == MULT) begin
                result_d = acc_step[WIDTH:1];
                exc_d    = (acc_step[2*WIDTH:WIDTH+1] != {WIDTH{acc_step[WIDTH]}});
            end else if (last) begin
                result_d = dbz_q ? '0 : (neg_q ? -quot : quot);
                exc_d    = dbz_q | ovf_q;
            end
        end else begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            neg_q    <= 1'b0;
            dbz_q    <= 1'b0;
            ovf_q    <= 1'b0;
            result_q <= '0;
            exc_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            neg_q    <= neg_d;
            dbz_q    <= dbz_d;
            ovf_q    <= ovf_d;
            result_q <= result_d;
            exc_q    <= exc_d;
        end
    end

    cnt_in_range: assert property (@(posedge clock) disable iff (!reset)
        (state_q == MULT || state_q == DIV) |-> (cnt_q < CNT_W'(WIDTH)));
endmodule
